// File: rtl/sw_debounce_if.sv
// Switch bus between board-side raw levels and the debounced/edge outputs.
// Master drives raw switch levels; slave (the debouncer) returns conditioned levels.
interface sw_debounce_if #(
   parameter int WIDTH = 3
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] db_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   modport master (
      output sw_raw,
      input  db_out,
      input  rise,
      input  fall
   );

   modport slave (
      input  sw_raw,
      output db_out,
      output rise,
      output fall
   );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: 2-flop sync, stability counter, optional rise/fall pulses.
// Latency STABLE_CYCLES+2 clocks; no backpressure. Edge pulses built only with SW_DEBOUNCE_EDGE_EN.
module sw_debounce #(
   parameter int WIDTH         = 3,
   parameter int CNT_W         = 16,
   parameter int STABLE_CYCLES = 50000
) (
   input logic            clk,
   input logic            rst,
   sw_debounce_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // A level must disagree with db_q on every sampled clock; any agreement restarts the count.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= bus.sw_raw;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.db_out = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   // Pulses register alongside db_q so they line up with the first cycle of the new level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= db_d & ~db_q;
         fall_q <= ~db_d & db_q;
      end
   end

   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
`else
   assign bus.rise = '0;
   assign bus.fall = '0;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: vector table, hand corner sequences, random vs window model.
module tb_sw_debounce;
   localparam int W  = 3;
   localparam int CW = 4;
   localparam int SC = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sw_debounce_if #(.WIDTH(W)) bus ();

   sw_debounce #(.WIDTH(W), .CNT_W(CW), .STABLE_CYCLES(SC)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: a level flips once the last SC synchronised samples all
   // disagree with it, none of them taken at or before the last flip or reset.
   int         edge_n     = 0;
   logic [2:0] hist [0:4095];
   int         last_reset = 0;
   int         last_flip [W];
   logic [2:0] mdb   = '0;
   logic [2:0] mrise = '0;
   logic [2:0] mfall = '0;

   typedef struct {
      logic       rv;
      logic [2:0] raw;
      logic [2:0] db;
      logic [2:0] ri;
      logic [2:0] fa;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got db/rise/fall=%b required %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic sample_bit(input int e, input int i);
      if (e - 2 <= last_reset) return 1'b0;
      return hist[e-2][i];
   endfunction

   task automatic model_edge(input logic [2:0] raw, input logic rv);
      edge_n++;
      if (edge_n < 4096) hist[edge_n] = raw;
      mrise = '0;
      mfall = '0;
      if (!rv) begin
         last_reset = edge_n;
         mdb        = '0;
      end else begin
         for (int i = 0; i < W; i++) begin
            int from;
            bit ok;
            from = (last_flip[i] > last_reset) ? last_flip[i] : last_reset;
            if (edge_n - SC >= from) begin
               ok = 1'b1;
               for (int e = edge_n - SC + 1; e <= edge_n; e++)
                  if (sample_bit(e, i) == mdb[i]) ok = 1'b0;
               if (ok) begin
                  mdb[i]       = ~mdb[i];
                  last_flip[i] = edge_n;
                  if (mdb[i]) mrise[i] = 1'b1;
                  else        mfall[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic step(input logic [2:0] raw, input logic rv);
      bus.sw_raw = raw;
      rst        = rv;
      @(posedge clk);
      #2;
      model_edge(raw, rv);
      check("model", {bus.db_out, bus.rise, bus.fall},
            {mdb, EN ? mrise : 3'b000, EN ? mfall : 3'b000});
   endtask

   task automatic run_until(input logic [2:0] raw, input logic [2:0] target, output int n);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         step(raw, 1'b1);
         if (bus.db_out == target) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [2:0] r;
      logic       rv;
      for (int i = 0; i < W; i++) last_flip[i] = 0;
      bus.sw_raw = 3'b000;
      rst        = 1'b0;

      tbl[0] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[1] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      for (int k = 2; k <= 6; k++) tbl[k] = '{1'b1, 3'b001, 3'b000, 3'b000, 3'b000};
      tbl[7] = '{1'b1, 3'b001, 3'b001, 3'b001, 3'b000};
      tbl[8] = '{1'b1, 3'b001, 3'b001, 3'b000, 3'b000};
      for (int k = 9; k <= 13; k++) tbl[k] = '{1'b1, 3'b000, 3'b001, 3'b000, 3'b000};
      tbl[14] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b001};
      tbl[15] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000};

      for (int k = 0; k < 16; k++) begin
         step(tbl[k].raw, tbl[k].rv);
         check($sformatf("vec%0d", k), {bus.db_out, bus.rise, bus.fall},
               {tbl[k].db, EN ? tbl[k].ri : 3'b000, EN ? tbl[k].fa : 3'b000});
      end

      // Glitch on bit 2 held for SC-1 clocks must never escape.
      for (int k = 0; k < 11; k++) begin
         step((k < 3) ? 3'b100 : 3'b000, 1'b1);
         check("glitch", {6'b0, bus.db_out[2], bus.rise[2], bus.fall[2]}, 9'b0);
      end

      step(3'b010, 1'b1);
      step(3'b000, 1'b1);
      step(3'b010, 1'b1);
      step(3'b000, 1'b1);
      run_until(3'b010, 3'b010, n);
      check_int("bounce_latency", n, SC + 2);
      run_until(3'b000, 3'b000, n);
      check_int("bounce_release", n, SC + 2);

      run_until(3'b111, 3'b111, n);
      check_int("all_rise_latency", n, SC + 2);
      check("all_rise_pulse", {bus.db_out, bus.rise, bus.fall},
            {3'b111, EN ? 3'b111 : 3'b000, 3'b000});
      run_until(3'b000, 3'b000, n);
      check_int("all_fall_latency", n, SC + 2);
      check("all_fall_pulse", {bus.db_out, bus.rise, bus.fall},
            {3'b000, 3'b000, EN ? 3'b111 : 3'b000});

      for (int k = 0; k < 3; k++) step(3'b001, 1'b1);
      step(3'b001, 1'b0);
      check("reset_mid", {bus.db_out, bus.rise, bus.fall}, 9'b0);
      run_until(3'b001, 3'b001, n);
      check_int("reset_release_latency", n, SC + 2);

      r = 3'b001;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 2)] = ~r[$urandom_range(0, 2)];
         if ($urandom_range(0, 7) == 0) r = 3'($urandom);
         rv = ($urandom_range(0, 199) != 0);
         step(r, rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
